// File: rtl/cajero_pkg.sv
// Shared types and constants for the cashier transaction sequencer.
// The optional inactivity timeout (CAJERO_TIMEOUT_EN) lives in cajero_control.
package cajero_pkg;

   localparam int ANCHO_BALANCE = 64;
   localparam int ANCHO_MONTO   = 32;
   localparam int ANCHO_PIN     = 16;
   localparam int DIGITOS_PIN   = 4;
   localparam int MAX_INTENTOS  = 3;

   localparam logic TIPO_DEPOSITO = 1'b0;
   localparam logic TIPO_RETIRO   = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      PIN,
      VALIDA,
      MONTO,
      EJECUTA,
      BLOQUEO
   } estado_t;

   // Deposit add that clamps at all-ones instead of wrapping.
   function automatic logic [ANCHO_BALANCE-1:0] suma_saturada(
      input logic [ANCHO_BALANCE-1:0] a,
      input logic [ANCHO_MONTO-1:0]   b
   );
      logic [ANCHO_BALANCE:0] s;
      s = {1'b0, a} + {{(ANCHO_BALANCE-ANCHO_MONTO+1){1'b0}}, b};
      return s[ANCHO_BALANCE] ? '1 : s[ANCHO_BALANCE-1:0];
   endfunction

endpackage

// File: rtl/cajero_pin_captura.sv
// PIN digit capture: shift register plus digit counter, cleared by the controller.
module cajero_pin_captura
   import cajero_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 limpiar,
   input  logic                 captura_en,
   input  logic                 digito_stb,
   input  logic [3:0]           digito,
   output logic [ANCHO_PIN-1:0] pin_capturado,
   output logic                 pin_completo
);

   localparam int ANCHO_CUENTA = $clog2(DIGITOS_PIN + 1);

   logic [ANCHO_CUENTA-1:0] cuenta;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cuenta        <= '0;
         pin_capturado <= '0;
      end else if (limpiar) begin
         cuenta        <= '0;
         pin_capturado <= '0;
      end else if (captura_en && digito_stb) begin
         cuenta        <= cuenta + 1'b1;
         pin_capturado <= {pin_capturado[ANCHO_PIN-5:0], digito};
      end
   end

   // High while the final digit is being accepted, so the controller leaves PIN on that same edge.
   assign pin_completo = captura_en && digito_stb &&
                         (cuenta == ANCHO_CUENTA'(DIGITOS_PIN - 1));

endmodule

// File: rtl/cajero_control.sv
// Cashier transaction sequencer: card, PIN check with lockout, one deposit/withdrawal.
// Define CAJERO_TIMEOUT_EN to abandon PIN/MONTO after TIMEOUT_CICLOS idle cycles.
//
// state   | meaning
// IDLE    | waiting for a card; loads balance_inicial on acceptance
// PIN     | collecting keypad digits
// VALIDA  | comparing captured PIN, updating attempt count
// MONTO   | waiting for amount strobe
// EJECUTA | applying deposit/withdrawal to balance
// BLOQUEO | locked out until reset
module cajero_control
   import cajero_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = 1000
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     tarjeta_recibida,
   input  logic                     tipo_trans,
   input  logic                     digito_stb,
   input  logic [3:0]               digito,
   input  logic [ANCHO_PIN-1:0]     pin,
   input  logic [ANCHO_BALANCE-1:0] balance_inicial,
   input  logic [ANCHO_MONTO-1:0]   monto,
   input  logic                     monto_stb,
   output logic [ANCHO_BALANCE-1:0] balance,
   output logic                     balance_actualizado,
   output logic                     entregar_dinero,
   output logic                     pin_incorrecto,
   output logic                     advertencia,
   output logic                     bloqueo,
   output logic                     fondos_insuficientes
);

   localparam int ANCHO_INTENTOS = $clog2(MAX_INTENTOS + 1);

   estado_t                    estado;
   logic [ANCHO_INTENTOS-1:0]  intentos;
   logic [ANCHO_MONTO-1:0]     monto_reg;
   logic                       tipo_reg;
   logic [ANCHO_PIN-1:0]       pin_capturado;
   logic                       pin_completo;
   logic [ANCHO_BALANCE-1:0]   monto_ext;

   assign monto_ext = {{(ANCHO_BALANCE-ANCHO_MONTO){1'b0}}, monto_reg};

   cajero_pin_captura u_pin_captura (
      .clock         (clock),
      .reset         (reset),
      .limpiar       ((estado == IDLE) || (estado == VALIDA)),
      .captura_en    (estado == PIN),
      .digito_stb    (digito_stb),
      .digito        (digito),
      .pin_capturado (pin_capturado),
      .pin_completo  (pin_completo)
   );

`ifdef CAJERO_TIMEOUT_EN
   localparam int ANCHO_TIMER = $clog2(TIMEOUT_CICLOS + 1);
   localparam logic [ANCHO_TIMER-1:0] CARGA_TIMER = ANCHO_TIMER'(TIMEOUT_CICLOS - 1);

   logic [ANCHO_TIMER-1:0] timer;
   logic                   expira;

   assign expira = (timer == '0);
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado               <= IDLE;
         intentos             <= '0;
         monto_reg            <= '0;
         tipo_reg             <= TIPO_DEPOSITO;
         balance              <= '0;
         balance_actualizado  <= 1'b0;
         entregar_dinero      <= 1'b0;
         pin_incorrecto       <= 1'b0;
         advertencia          <= 1'b0;
         bloqueo              <= 1'b0;
         fondos_insuficientes <= 1'b0;
`ifdef CAJERO_TIMEOUT_EN
         timer                <= '0;
`endif
      end else begin
         balance_actualizado  <= 1'b0;
         entregar_dinero      <= 1'b0;
         pin_incorrecto       <= 1'b0;
         fondos_insuficientes <= 1'b0;

         case (estado)
            IDLE: begin
               advertencia <= 1'b0;
               if (tarjeta_recibida) begin
                  balance <= balance_inicial;
                  estado  <= PIN;
`ifdef CAJERO_TIMEOUT_EN
                  timer   <= CARGA_TIMER;
`endif
               end
            end

            PIN: begin
`ifdef CAJERO_TIMEOUT_EN
               if (digito_stb)  timer  <= CARGA_TIMER;
               else if (expira) estado <= IDLE;
               else             timer  <= timer - 1'b1;
`endif
               if (pin_completo) estado <= VALIDA;
            end

            VALIDA: begin
               if (pin_capturado == pin) begin
                  intentos    <= '0;
                  advertencia <= 1'b0;
                  estado      <= MONTO;
               end else begin
                  pin_incorrecto <= 1'b1;
                  intentos       <= intentos + 1'b1;
                  if (intentos == ANCHO_INTENTOS'(MAX_INTENTOS - 1)) begin
                     bloqueo <= 1'b1;
                     estado  <= BLOQUEO;
                  end else begin
                     if (intentos == ANCHO_INTENTOS'(1)) advertencia <= 1'b1;
                     estado <= PIN;
                  end
               end
`ifdef CAJERO_TIMEOUT_EN
               timer <= CARGA_TIMER;
`endif
            end

            MONTO: begin
               if (monto_stb) begin
                  monto_reg <= monto;
                  tipo_reg  <= tipo_trans;
                  estado    <= EJECUTA;
               end
`ifdef CAJERO_TIMEOUT_EN
               else if (expira) estado <= IDLE;
               else             timer  <= timer - 1'b1;
`endif
            end

            EJECUTA: begin
               if (tipo_reg == TIPO_RETIRO) begin
                  if (monto_ext > balance) begin
                     fondos_insuficientes <= 1'b1;
                  end else begin
                     balance             <= balance - monto_ext;
                     entregar_dinero     <= 1'b1;
                     balance_actualizado <= 1'b1;
                  end
               end else begin
                  balance             <= suma_saturada(balance, monto_reg);
                  balance_actualizado <= 1'b1;
               end
               estado <= IDLE;
            end

            BLOQUEO: estado <= BLOQUEO;

            default: estado <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cajero_control.sv
// Randomized scoreboard bench for cajero_control; covers the timeout path when CAJERO_TIMEOUT_EN is defined.
module tb_cajero_control;
   import cajero_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        tarjeta_recibida = 1'b0;
   logic        tipo_trans = 1'b0;
   logic        digito_stb = 1'b0;
   logic [3:0]  digito = '0;
   logic [15:0] pin = '0;
   logic [63:0] balance_inicial = '0;
   logic [31:0] monto = '0;
   logic        monto_stb = 1'b0;
   logic [63:0] balance;
   logic        balance_actualizado, entregar_dinero, pin_incorrecto;
   logic        advertencia, bloqueo, fondos_insuficientes;

   always #5 clock = ~clock;

   cajero_control #(.TIMEOUT_CICLOS(20)) dut (
      .clock                (clock),
      .reset                (reset),
      .tarjeta_recibida     (tarjeta_recibida),
      .tipo_trans           (tipo_trans),
      .digito_stb           (digito_stb),
      .digito               (digito),
      .pin                  (pin),
      .balance_inicial      (balance_inicial),
      .monto                (monto),
      .monto_stb            (monto_stb),
      .balance              (balance),
      .balance_actualizado  (balance_actualizado),
      .entregar_dinero      (entregar_dinero),
      .pin_incorrecto       (pin_incorrecto),
      .advertencia          (advertencia),
      .bloqueo              (bloqueo),
      .fondos_insuficientes (fondos_insuficientes)
   );

   typedef struct packed {
      logic        pin_inc;
      logic        adv;
      logic        bloq;
      logic        act;
      logic        entregar;
      logic        fondos;
      logic [63:0] bal;
   } esperado_t;

   esperado_t sb[$];
   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [63:0] m_balance = '0;
   int          m_intentos = 0;
   logic        m_adv = 1'b0;
   logic        m_bloq = 1'b0;

   // Monitor: every result pulse must match the oldest expected event.
   always @(negedge clock) begin
      if (!reset && (pin_incorrecto || balance_actualizado || entregar_dinero || fondos_insuficientes)) begin
         esperado_t act;
         esperado_t exp_v;
         act = {pin_incorrecto, advertencia, bloqueo, balance_actualizado,
                entregar_dinero, fondos_insuficientes, balance};
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got %h, expected no event", act);
         end else begin
            exp_v = sb.pop_front();
            if (act !== exp_v) begin
               errors++;
               $display("FAIL result_event: got %h, expected %h", act, exp_v);
            end
         end
      end
   end

   task automatic chk(input string nombre, input logic [63:0] actual, input logic [63:0] esperado);
      checks++;
      if (actual !== esperado) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", nombre, actual, esperado);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic tarjeta(input logic [63:0] bal, input logic [15:0] p);
      pin = p;
      balance_inicial = bal;
      tarjeta_recibida = 1'b1;
      step();
      tarjeta_recibida = 1'b0;
      if (!m_bloq) begin
         m_balance = bal;
         m_adv = 1'b0;
      end
      chk("balance_load", balance, m_balance);
   endtask

   task automatic modelo_pin(input logic [15:0] digs);
      if (m_bloq) return;
      if (digs == pin) begin
         m_intentos = 0;
         m_adv = 1'b0;
      end else begin
         m_intentos++;
         if (m_intentos == 2) m_adv = 1'b1;
         if (m_intentos == 3) m_bloq = 1'b1;
         sb.push_back({1'b1, m_adv, m_bloq, 1'b0, 1'b0, 1'b0, m_balance});
      end
   endtask

   task automatic intento(input logic [15:0] digs, input bit ruido);
      logic [15:0] d;
      d = digs;
      modelo_pin(d);
      for (int i = 3; i >= 0; i--) begin
         digito = d[i*4 +: 4];
         digito_stb = 1'b1;
         monto_stb = ruido && ($urandom_range(0, 1) == 1);
         monto = $urandom;
         step();
         digito_stb = 1'b0;
         monto_stb = 1'b0;
         if (i > 0) step($urandom_range(0, 2));
      end
      step();
      chk("advertencia", {63'b0, advertencia}, {63'b0, m_adv});
      chk("bloqueo", {63'b0, bloqueo}, {63'b0, m_bloq});
   endtask

   task automatic transaccion(input logic tipo, input logic [31:0] m, input bit ruido);
      logic [64:0] suma;
      if (ruido) begin
         repeat ($urandom_range(0, 2)) begin
            digito = 4'($urandom);
            digito_stb = 1'b1;
            step();
            digito_stb = 1'b0;
            step($urandom_range(0, 1));
         end
      end
      if (!m_bloq) begin
         if (tipo) begin
            if (64'(m) > m_balance) begin
               sb.push_back({1'b0, m_adv, 1'b0, 1'b0, 1'b0, 1'b1, m_balance});
            end else begin
               m_balance = m_balance - 64'(m);
               sb.push_back({1'b0, m_adv, 1'b0, 1'b1, 1'b1, 1'b0, m_balance});
            end
         end else begin
            suma = {1'b0, m_balance} + 65'(m);
            m_balance = (suma > 65'h0_FFFF_FFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF_FFFF : suma[63:0];
            sb.push_back({1'b0, m_adv, 1'b0, 1'b1, 1'b0, 1'b0, m_balance});
         end
      end
      monto = m;
      tipo_trans = tipo;
      monto_stb = 1'b1;
      digito_stb = ruido;
      step();
      monto_stb = 1'b0;
      digito_stb = 1'b0;
      step();
      chk("balance_after", balance, m_balance);
   endtask

   initial begin
      logic [63:0] bal;
      logic [15:0] pinv;
      logic [31:0] m;

      step(2);
      chk("reset_outputs",
          {balance ^ 64'h0, 57'b0, balance_actualizado, entregar_dinero, pin_incorrecto,
           advertencia, bloqueo, fondos_insuficientes, 1'b0} == 128'h0 ? 64'h0 : 64'h1, 64'h0);
      reset = 1'b0;
      step();

      // Correct PIN, withdrawal 300 from 1000
      tarjeta(64'd1000, 16'h1234);
      intento(16'h1234, 1'b0);
      transaccion(TIPO_RETIRO, 32'd300, 1'b0);
      chk("withdraw_700", balance, 64'd700);

      // Insufficient funds
      tarjeta(64'd100, 16'h1234);
      intento(16'h1234, 1'b0);
      transaccion(TIPO_RETIRO, 32'd101, 1'b0);
      chk("funds_held", balance, 64'd100);

      // Withdraw exactly the balance
      tarjeta(64'd500, 16'hA0F5);
      intento(16'hA0F5, 1'b0);
      transaccion(TIPO_RETIRO, 32'd500, 1'b0);
      chk("withdraw_all", balance, 64'd0);

      // Deposit saturation
      tarjeta(64'hFFFF_FFFF_FFFF_FFF0, 16'h1234);
      intento(16'h1234, 1'b0);
      transaccion(TIPO_DEPOSITO, 32'd32, 1'b0);
      chk("deposit_sat", balance, 64'hFFFF_FFFF_FFFF_FFFF);

      // Randomized sessions with up to two wrong attempts and ignored strobes
      for (int s = 0; s < 30; s++) begin
         case ($urandom_range(0, 2))
            0:       bal = 64'($urandom_range(0, 2000));
            1:       bal = {$urandom, $urandom};
            default: bal = 64'hFFFF_FFFF_0000_0000 | 64'($urandom);
         endcase
         case ($urandom_range(0, 2))
            0:       m = 32'($urandom_range(0, 3000));
            1:       m = $urandom;
            default: m = bal[31:0];
         endcase
         pinv = 16'($urandom);
         tarjeta(bal, pinv);
         repeat ($urandom_range(0, 2)) intento(pinv ^ 16'($urandom_range(1, 65535)), 1'b1);
         intento(pinv, 1'b1);
         transaccion(1'($urandom_range(0, 1)), m, 1'b1);
         step($urandom_range(0, 2));
      end

      // Lockout, then everything ignored
      tarjeta(64'd5000, 16'h1234);
      intento(16'h9999, 1'b0);
      intento(16'h9999, 1'b0);
      intento(16'h9999, 1'b0);
      tarjeta(64'd42, 16'h1234);
      intento(16'h1234, 1'b0);
      transaccion(TIPO_RETIRO, 32'd10, 1'b1);
      chk("lock_sticky", {63'b0, bloqueo}, 64'd1);
      chk("lock_balance", balance, 64'd5000);

      // Reset after the 2nd digit
      tarjeta(64'd777, 16'h4321);
      for (int i = 0; i < 2; i++) begin
         digito = 4'(4 - i);
         digito_stb = 1'b1;
         step();
         digito_stb = 1'b0;
      end
      reset = 1'b1;
      #1;
      chk("midop_reset_balance", balance, 64'd0);
      chk("midop_reset_flags",
          {58'b0, balance_actualizado, entregar_dinero, pin_incorrecto, advertencia, bloqueo, fondos_insuficientes},
          64'd0);
      m_balance = '0;
      m_intentos = 0;
      m_adv = 1'b0;
      m_bloq = 1'b0;
      sb.delete();
      step();
      reset = 1'b0;
      step();
      tarjeta(64'd777, 16'h4321);
      intento(16'h4321, 1'b0);
      transaccion(TIPO_DEPOSITO, 32'd10, 1'b0);
      chk("after_reset_deposit", balance, 64'd787);

`ifdef CAJERO_TIMEOUT_EN
      // Abandon after two digits; the session must time out silently
      tarjeta(64'd50, 16'h1111);
      for (int i = 0; i < 2; i++) begin
         digito = 4'd1;
         digito_stb = 1'b1;
         step();
         digito_stb = 1'b0;
      end
      step(25);
      tarjeta(64'd60, 16'h2222);
      intento(16'h2222, 1'b0);
      transaccion(TIPO_RETIRO, 32'd60, 1'b0);
      chk("after_timeout", balance, 64'd0);
`endif

      step(5);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule

// File: doc/cajero_control.md
# cajero_control

Transaction sequencer for the automatic cashier. Sits between the card and keypad inputs and the account balance register. Accepts a card, collects and checks a 4-digit PIN, counts failed attempts up to a lockout, then executes one deposit or withdrawal against a 64-bit balance and reports the result as registered pulses and levels.

## Interface
- TIMEOUT_CICLOS, 1000: inactivity limit in clock cycles; used only when the timeout feature is compiled in.
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state and outputs.
- tarjeta_recibida  input  1  card inserted; level, sampled in IDLE only.
- tipo_trans  input  1  transaction type: 0 = deposit, 1 = withdrawal. Sampled together with monto_stb.
- digito_stb  input  1  one-cycle strobe qualifying digito.
- digito  input  4  keypad digit. The raw nibble is accepted, values 0–15.
- pin  input  16  stored PIN of the card, 4 nibbles, MSB nibble is the first digit.
- balance_inicial  input  64  account balance, loaded on card acceptance.
- monto  input  32  transaction amount, qualified by monto_stb.
- monto_stb  input  1  one-cycle strobe qualifying monto and tipo_trans.
- balance  output  64  current balance register.
- balance_actualizado  output  1  one-cycle pulse when balance changes.
- entregar_dinero  output  1  one-cycle pulse on a successful withdrawal.
- pin_incorrecto  output  1  one-cycle pulse on each PIN mismatch.
- advertencia  output  1  level, high after the 2nd consecutive mismatch; cleared on IDLE.
- bloqueo  output  1  level, sticky lockout; cleared only by reset.
- fondos_insuficientes  output  1  one-cycle pulse when a withdrawal is rejected.

## Operation
- Reset values: all outputs 0, balance 0, state IDLE, attempt count 0, digit count 0.
- States:
  - IDLE: when tarjeta_recibida=1, load balance_inicial into balance, clear digit count, and go to PIN.
  - PIN: each digito_stb shifts digito into a 16-bit capture register, first digit ending in [15:12]. The 4th strobe goes to VALIDA.
  - VALIDA: one cycle.
    - Match: attempt count 0, advertencia 0, go to MONTO.
    - Mismatch: pulse pin_incorrecto and increment the attempt count.
      - Count 2: set advertencia and go to PIN.
      - Count 3: set bloqueo and go to BLOQUEO.
      - Otherwise: go to PIN with digit count cleared.
  - MONTO: wait for monto_stb, then go to EJECUTA, capturing monto and tipo_trans.
  - EJECUTA: one cycle.
    - Withdrawal with monto > balance: pulse fondos_insuficientes; balance unchanged.
    - Withdrawal otherwise: balance -= monto; pulse entregar_dinero and balance_actualizado.
    - Deposit: balance += monto, zero-extended to 64 bits. Saturate at 2^64−1. balance_actualizado pulses even when saturated.
    - Always go to IDLE afterwards.
  - BLOQUEO: absorbing state. All strobes and tarjeta_recibida are ignored until reset.
- Strobes arriving in states that do not consume them are ignored: digito_stb outside PIN, monto_stb outside MONTO.
- digito_stb and monto_stb asserted in the same cycle: only the strobe valid for the current state is used.
- The attempt count persists across card sessions and is cleared only by a correct PIN or by reset.
- The withdrawal comparison is unsigned, with monto zero-extended; monto = balance is allowed and leaves balance 0.

## Timing
- PIN result: pin_incorrecto, advertencia and bloqueo are registered. They are visible in the cycle after VALIDA, i.e. 2 edges after the edge that sampled the 4th digit.
- Transaction result: balance, balance_actualizado, entregar_dinero and fondos_insuficientes are visible 2 edges after the edge that sampled monto_stb.
- Back-to-back: IDLE is re-entered the cycle after EJECUTA. A held tarjeta_recibida starts a new session immediately.
- Reset mid-operation: asynchronous. All state and outputs return to reset values with no completion of a pending transaction, and balance returns to 0.

## Configuration
- CAJERO_TIMEOUT_EN defined:
  - A counter clears on entering PIN or MONTO and on every accepted strobe.
  - On reaching TIMEOUT_CICLOS in PIN or MONTO, go to IDLE with no output pulse; balance is held and the attempt count is kept.
- CAJERO_TIMEOUT_EN undefined: no counter; PIN and MONTO wait indefinitely. TIMEOUT_CICLOS is unused.

## Structure
- Package cajero_pkg holds:
  - state enum (IDLE, PIN, VALIDA, MONTO, EJECUTA, BLOQUEO);
  - ANCHO_BALANCE=64, ANCHO_MONTO=32, ANCHO_PIN=16;
  - DIGITOS_PIN=4, MAX_INTENTOS=3;
  - TIPO_DEPOSITO=0, TIPO_RETIRO=1.
- Sub-module cajero_pin_captura: shift register plus digit counter. It provides the captured PIN and a "4 digits complete" flag, and is cleared by the controller.

## Test plan
- Correct PIN, withdrawal: pin=16'h1234, digits 1,2,3,4, balance_inicial=1000, monto=300 withdrawal → entregar_dinero and balance_actualizado pulse once, balance=700, return to IDLE.
- Insufficient funds: balance_inicial=100, monto=101 withdrawal → fondos_insuficientes pulse, balance=100, no entregar_dinero.
- Lockout: three sessions with wrong digits 9,9,9,9 →
  - pin_incorrecto pulses 3 times;
  - advertencia rises after the 2nd;
  - bloqueo rises after the 3rd and stays high; later card and digits are ignored until reset.
- Deposit saturation: balance_inicial=64'hFFFF_FFFF_FFFF_FFF0, deposit monto=32 → balance=64'hFFFF_FFFF_FFFF_FFFF, balance_actualizado pulses.
- Reset mid-operation: assert reset after the 2nd digit → all outputs 0 and state IDLE in the same cycle; a fresh session with the correct PIN then succeeds.
- Timeout, CAJERO_TIMEOUT_EN with TIMEOUT_CICLOS=20: stop after 2 digits → IDLE after 20 cycles with no pulses; the following session works normally.
